lut_bank: RTL and testbench

LUT_BANK -- requirements
Module: lut_bank

---
 rtl/lut_pkg.sv | 19 +
 rtl/lut_load_fsm.sv | 77 +++++++
 rtl/lut_bank.sv | 136 +++++++++++++
 tb/tb_lut_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// lut_pkg: load-FSM states and default sizing for the banked lookup table.
// Build option LUT_PARITY_EN adds an even-parity bit to every stored entry.
package lut_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int BANKS_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    function automatic int bank_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/lut_load_fsm.sv
// lut_load_fsm: sequences a full-bank load, one accepted word per entry.
// Build option LUT_PARITY_EN does not affect this module.
module lut_load_fsm
    import lut_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BANK_W = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic              valid_i,
    output ld_state_e         state_o,
    output logic [BANK_W-1:0] bank_o,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              we_o,
    output logic              ready_o,
    output logic              done_o
);

    ld_state_e         state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            bank_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        ptr_d   = ptr_q;
        we_o    = 1'b0;
        ready_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    bank_d  = bank_i;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    we_o = 1'b1;
                    // The pointer parks on the last entry instead of wrapping.
                    if (&ptr_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;
    assign bank_o  = bank_q;
    assign ptr_o   = ptr_q;

endmodule

// File: rtl/lut_bank.sv
// lut_bank: multi-bank branch-target table with a streaming bank loader.
// Define LUT_PARITY_EN to store and check an even-parity bit per entry.
module lut_bank
    import lut_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int BANKS  = BANKS_DEF,
    localparam int BANK_W = bank_w(BANKS)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_busy,
    output logic              rd_perr,
    input  logic              ld_start,
    input  logic [BANK_W-1:0] ld_bank,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_done
);

`ifdef LUT_PARITY_EN
    localparam int ENT_W = DATA_W + 1;
`else
    localparam int ENT_W = DATA_W;
`endif
    localparam int IDX_W = BANK_W + ADDR_W;
    localparam logic [BANK_W:0] NBANKS = (BANK_W + 1)'(BANKS);

    logic [ENT_W-1:0] mem [2**IDX_W];

    ld_state_e         ld_state;
    logic [BANK_W-1:0] ld_bank_q;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_we;

    lut_load_fsm #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_fsm (
        .clk_i   (CLK),
        .reset_i (reset),
        .start_i (ld_start),
        .bank_i  (ld_bank),
        .valid_i (ld_valid),
        .state_o (ld_state),
        .bank_o  (ld_bank_q),
        .ptr_o   (ld_ptr),
        .we_o    (ld_we),
        .ready_o (ld_ready),
        .done_o  (ld_done)
    );

    logic [ENT_W-1:0] wr_ent;
    logic             wr_ok;

`ifdef LUT_PARITY_EN
    assign wr_ent = {^ld_data, ld_data};
`else
    assign wr_ent = ld_data;
`endif
    assign wr_ok = ld_we && ({1'b0, ld_bank_q} < NBANKS);

    // Table contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[{ld_bank_q, ld_ptr}] <= wr_ent;
        end
    end

    logic [ENT_W-1:0] rd_ent;
    logic             rd_ent_perr;
    logic             rd_oob;
    logic             rd_block;

    assign rd_ent   = mem[{rd_bank, rd_addr}];
    assign rd_oob   = {1'b0, rd_bank} >= NBANKS;
    assign rd_block = ((ld_state == LOAD) || (ld_state == DONE))
                      && (rd_bank == ld_bank_q);

`ifdef LUT_PARITY_EN
    assign rd_ent_perr = ^rd_ent;
`else
    assign rd_ent_perr = 1'b0;
`endif

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_busy_q, rd_busy_d;
    logic              rd_perr_q, rd_perr_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_busy_d  = 1'b0;
        rd_perr_d  = 1'b0;
        if (rd_en) begin
            if (rd_oob) begin
                rd_valid_d = 1'b1;
                rd_data_d  = '0;
            end else if (rd_block) begin
                rd_busy_d = 1'b1;
            end else begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_ent[DATA_W-1:0];
                rd_perr_d  = rd_ent_perr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_perr_q  <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
            rd_perr_q  <= rd_perr_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;
    assign rd_perr  = rd_perr_q;

endmodule

// File: tb/tb_lut_bank.sv
// tb_lut_bank: directed scenarios for the banked LUT and its loader.
// Parity-flip checks apply when LUT_PARITY_EN is defined.
module tb_lut_bank;

    logic        CLK = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_busy;
    logic        rd_perr;
    logic        ld_start;
    logic [1:0]  ld_bank;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    lut_bank #(
        .ADDR_W (8),
        .DATA_W (16),
        .BANKS  (3)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_busy  (rd_busy),
        .rd_perr  (rd_perr),
        .ld_start (ld_start),
        .ld_bank  (ld_bank),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_done  (ld_done)
    );

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load(input logic [1:0] b);
        ld_start = 1'b1;
        ld_bank  = b;
        cycle();
        ld_start = 1'b0;
    endtask

    task automatic load_words(input int first, input int last,
                              input logic [15:0] key,
                              output int dones, output int unready);
        dones   = 0;
        unready = 0;
        for (int i = first; i < last; i++) begin
            if (!ld_ready) unready++;
            ld_valid = 1'b1;
            ld_data  = 16'(i) ^ key;
            cycle();
            if (ld_done) dones++;
        end
        ld_valid = 1'b0;
    endtask

    task automatic read_one(input logic [1:0] b, input logic [7:0] a);
        rd_en   = 1'b1;
        rd_bank = b;
        rd_addr = a;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_busy !== 1'b0) begin n_bad++; $display("FAIL rst_rd_busy got %b want 0", rd_busy); end
        n_cmp++; if (rd_perr !== 1'b0) begin n_bad++; $display("FAIL rst_rd_perr got %b want 0", rd_perr); end
        n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL rst_rd_data got %h want 0000", rd_data); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL rst_ld_done got %b want 0", ld_done); end
        reset = 1'b0;
        cycle();
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ld_ready got %b want 0", ld_ready); end
    endtask

    task automatic test_load_basic();
        int d, u;
        start_load(2'd0);
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready got %b want 1", ld_ready); end
        load_words(0, 256, 16'h0F0F, d, u);
        n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL b0_done_count got %0d want 1", d); end
        n_cmp++; if (ld_done !== 1'b1) begin n_bad++; $display("FAIL b0_done_last got %b want 1", ld_done); end
        cycle();
        n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL b0_done_pulse got %b want 0", ld_done); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL b0_back_idle got %b want 0", ld_ready); end
        start_load(2'd1);
        load_words(0, 256, 16'hA5A5, d, u);
        n_cmp++; if (d !== 1 || u !== 0) begin n_bad++; $display("FAIL b1_load got done=%0d unready=%0d want 1/0", d, u); end
        cycle();
        read_one(2'd1, 8'h10);
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL b1_rd_valid got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 16'hA5B5) begin n_bad++; $display("FAIL b1_rd_data got %h want a5b5", rd_data); end
        read_one(2'd0, 8'hFF);
        n_cmp++; if (rd_data !== 16'h0FF0) begin n_bad++; $display("FAIL b0_rd_ff got %h want 0ff0", rd_data); end
    endtask

    task automatic test_hold();
        read_one(2'd1, 8'h10);
        cycle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 16'hA5B5) begin n_bad++; $display("FAIL hold_data got %h want a5b5", rd_data); end
    endtask

    task automatic test_concurrent_load();
        int d, u;
        start_load(2'd2);
        load_words(0, 128, 16'h5A5A, d, u);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL b2_early_done got %0d want 0", d); end
        read_one(2'd0, 8'h05);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0F0A) begin n_bad++; $display("FAIL other_bank_rd got v=%b d=%h want 1/0f0a", rd_valid, rd_data); end
        read_one(2'd2, 8'h00);
        n_cmp++; if (rd_valid !== 1'b0 || rd_busy !== 1'b1) begin n_bad++; $display("FAIL busy_rd got v=%b b=%b want 0/1", rd_valid, rd_busy); end
        n_cmp++; if (rd_data !== 16'h0F0A) begin n_bad++; $display("FAIL busy_hold got %h want 0f0a", rd_data); end
        ld_start = 1'b1;
        ld_bank  = 2'd0;
        cycle();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready got %b want 1", ld_ready); end
        load_words(128, 256, 16'h5A5A, d, u);
        n_cmp++; if (d !== 1 || u !== 0) begin n_bad++; $display("FAIL b2_finish got done=%0d unready=%0d want 1/0", d, u); end
        n_cmp++; if (ld_done !== 1'b1) begin n_bad++; $display("FAIL b2_done_last got %b want 1", ld_done); end
        read_one(2'd2, 8'hFF);
        n_cmp++; if (rd_valid !== 1'b0 || rd_busy !== 1'b1) begin n_bad++; $display("FAIL done_busy got v=%b b=%b want 0/1", rd_valid, rd_busy); end
        read_one(2'd2, 8'hFF);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h5AA5) begin n_bad++; $display("FAIL b2_rd_ff got v=%b d=%h want 1/5aa5", rd_valid, rd_data); end
        read_one(2'd2, 8'h80);
        n_cmp++; if (rd_data !== 16'h5ADA) begin n_bad++; $display("FAIL b2_rd_80 got %h want 5ada", rd_data); end
        read_one(2'd2, 8'h7F);
        n_cmp++; if (rd_data !== 16'h5A25) begin n_bad++; $display("FAIL b2_rd_7f got %h want 5a25", rd_data); end
        read_one(2'd0, 8'h05);
        n_cmp++; if (rd_data !== 16'h0F0A) begin n_bad++; $display("FAIL b0_untouched got %h want 0f0a", rd_data); end
    endtask

    task automatic test_oob();
        read_one(2'd3, 8'h00);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin n_bad++; $display("FAIL oob_rd got v=%b d=%h want 1/0000", rd_valid, rd_data); end
        n_cmp++; if (rd_perr !== 1'b0 || rd_busy !== 1'b0) begin n_bad++; $display("FAIL oob_flags got p=%b b=%b want 0/0", rd_perr, rd_busy); end
    endtask

    task automatic test_reset_abort();
        int d, u, late;
        start_load(2'd0);
        load_words(0, 100, 16'h3C3C, d, u);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL abort_early_done got %0d want 0", d); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++; if (ld_ready !== 1'b0 || ld_done !== 1'b0) begin n_bad++; $display("FAIL abort_state got r=%b d=%b want 0/0", ld_ready, ld_done); end
        late = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (ld_done) late++;
        end
        n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", late); end
        read_one(2'd0, 8'd0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h3C3C) begin n_bad++; $display("FAIL abort_rd0 got v=%b d=%h want 1/3c3c", rd_valid, rd_data); end
        read_one(2'd0, 8'd99);
        n_cmp++; if (rd_data !== 16'h3C5F) begin n_bad++; $display("FAIL abort_rd99 got %h want 3c5f", rd_data); end
        read_one(2'd0, 8'd100);
        n_cmp++; if (rd_data !== 16'h0F6B) begin n_bad++; $display("FAIL abort_rd100 got %h want 0f6b", rd_data); end
        start_load(2'd0);
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready got %b want 1", ld_ready); end
        load_words(0, 256, 16'h3C3C, d, u);
        n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL restart_done got %0d want 1", d); end
        cycle();
        read_one(2'd0, 8'd100);
        n_cmp++; if (rd_data !== 16'h3C58) begin n_bad++; $display("FAIL restart_rd100 got %h want 3c58", rd_data); end
    endtask

    task automatic test_parity();
        read_one(2'd1, 8'd3);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'hA5A6) begin n_bad++; $display("FAIL par_rd3 got v=%b d=%h want 1/a5a6", rd_valid, rd_data); end
        n_cmp++; if (rd_perr !== 1'b0) begin n_bad++; $display("FAIL par_clean got %b want 0", rd_perr); end
`ifdef LUT_PARITY_EN
        dut.mem[10'h103] = dut.mem[10'h103] ^ 17'h00001;
        read_one(2'd1, 8'd3);
        n_cmp++; if (rd_valid !== 1'b1 || rd_perr !== 1'b1) begin n_bad++; $display("FAIL par_flip got v=%b p=%b want 1/1", rd_valid, rd_perr); end
`else
        read_one(2'd1, 8'd3);
        n_cmp++; if (rd_valid !== 1'b1 || rd_perr !== 1'b0) begin n_bad++; $display("FAIL par_tied got v=%b p=%b want 1/0", rd_valid, rd_perr); end
`endif
        read_one(2'd1, 8'd4);
        n_cmp++; if (rd_data !== 16'hA5A1 || rd_perr !== 1'b0) begin n_bad++; $display("FAIL par_rd4 got d=%h p=%b want a5a1/0", rd_data, rd_perr); end
    endtask

    initial begin
        reset    = 1'b1;
        rd_en    = 1'b0;
        rd_bank  = 2'd0;
        rd_addr  = 8'd0;
        ld_start = 1'b0;
        ld_bank  = 2'd0;
        ld_data  = 16'd0;
        ld_valid = 1'b0;
        test_reset();
        test_load_basic();
        test_hold();
        test_concurrent_load();
        test_oob();
        test_reset_abort();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
